// File: rtl/aes128_encrypt_ctrl_pkg.sv
// Shared AES-128 definitions: FSM encodings, round count, S-box, Rcon and the
// combinational round transforms used by the encryption controller.
package aes128_encrypt_ctrl_pkg;

   localparam int AES_NR = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Entry b sits at bits [8*(255-b) +: 8], i.e. row 0 is the most significant.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return SBOX_TBL[idx +: 8];
   endfunction

   function automatic logic [7:0] rcon_f(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         o[8*i +: 8] = sbox(s[8*i +: 8]);
      end
      return o;
   endfunction

   // Byte 4c+r holds row r of column c; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                  input logic [127:0] k);
      return s ^ k;
   endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One on-the-fly AES-128 key-schedule step: derives the next round key from
// the current one using RotWord, SubWord, Rcon and the word XOR chain.
module aes128_key_step
   import aes128_encrypt_ctrl_pkg::*;
(
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon,
   output logic [127:0] key_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] temp;
   logic [31:0] n0, n1, n2, n3;

   assign w0 = key_in[127:96];
   assign w1 = key_in[95:64];
   assign w2 = key_in[63:32];
   assign w3 = key_in[31:0];

   assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                 ^ {rcon, 24'h000000};

   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, key schedule
// computed on the fly, valid/ready handshake on both the block input and output.
module aes128_encrypt_ctrl
   import aes128_encrypt_ctrl_pkg::*;
#(
   parameter int NR               = AES_NR,
   parameter bit HOLD_OUT_ON_IDLE = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [3:0]   round
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   logic [1:0]   fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [127:0] out_data_q, out_data_d;
   logic [3:0]   round_q, round_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] sr_w, mc_w, nk_w, rnd_w;
   logic [7:0]   rcon_w;
   logic         last_rnd_w;

   assign rcon_w     = rcon_f(round_q);
   assign last_rnd_w = (round_q == LAST_RND);

   aes128_key_step u_key_step (
      .key_in  (key_q),
      .rcon    (rcon_w),
      .key_out (nk_w)
   );

   // The final round skips MixColumns via this mux.
   assign sr_w  = shift_rows(sub_bytes(state_q));
   assign mc_w  = last_rnd_w ? sr_w : mix_columns(sr_w);
   assign rnd_w = add_round_key(mc_w, nk_w);

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      key_d       = key_q;
      round_d     = round_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = add_round_key(in_data, in_key);
               key_d   = in_key;
               round_d = 4'd1;
               fsm_d   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_d = rnd_w;
            key_d   = nk_w;
            if (last_rnd_w) begin
               out_data_d  = rnd_w;
               out_valid_d = 1'b1;
               fsm_d       = ST_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               round_d     = 4'd0;
               fsm_d       = ST_IDLE;
               if (!HOLD_OUT_ON_IDLE) begin
                  out_data_d = '0;
               end
            end
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= ST_IDLE;
         state_q     <= '0;
         key_q       <= '0;
         round_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         key_q       <= key_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = (fsm_q == ST_IDLE);
   assign busy      = (fsm_q != ST_IDLE);
   assign round     = round_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Scoreboard bench for the iterative AES-128 controller, with a matrix-based
// AES reference model that derives its S-box from GF(2^8) inversion.
module tb_aes128_encrypt_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic [3:0]   round;

   always #5 clk = ~clk;

   aes128_encrypt_ctrl #(.NR(10), .HOLD_OUT_ON_IDLE(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .round     (round)
   );

   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sbox_m [256];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] b);
      return {b[6:0], b[7]};
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, r, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv;
         r = inv;
         for (int k = 0; k < 4; k++) begin
            r = rotl1(r);
            s = s ^ r;
         end
         sbox_m[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r][c] = sbox_m[s[r][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               if (rnd < 10)
                  s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                            ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
            end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- scoreboard monitor ----------------
   logic [127:0] exp_q [$];
   int           acc_q [$];
   logic [127:0] out_hist [$];
   logic [127:0] last_out = '0;
   int           cyc = 0;
   int           acc_cnt = 0;
   int           out_cnt = 0;
   int           last_acc_cyc = 0;

   initial begin
      logic         prev_ov, prev_or;
      logic [127:0] prev_od, e;
      prev_ov = 1'b0; prev_or = 1'b0; prev_od = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
            prev_or = 1'b0;
         end else begin
            if (prev_ov && !prev_or) begin
               chk("out_valid_held", 128'(out_valid), 128'd1);
               chk("out_data_stable", out_data, prev_od);
            end
            if (out_valid) chk("in_ready_low_when_done", 128'(in_ready), 128'd0);
            if (out_valid && !prev_ov) begin
               if (acc_q.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'd0);
               else chk("latency", 128'(cyc - acc_q[0]), 128'd11);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", out_data, 128'hx);
               end else begin
                  e = exp_q.pop_front();
                  void'(acc_q.pop_front());
                  chk("ciphertext", out_data, e);
               end
               last_out = out_data;
               out_hist.push_back(out_data);
               out_cnt++;
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(aes_model(in_data, in_key));
               acc_q.push_back(cyc);
               last_acc_cyc = cyc;
               acc_cnt++;
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_acc(output int c);
      int start;
      bit ok;
      start = acc_cnt; ok = 1'b0; c = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk); #1;
         if (acc_cnt != start) begin ok = 1'b1; c = last_acc_cyc; end
      end
      chk("accept_timeout", 128'(ok), 128'd1);
   endtask

   task automatic send(input logic [127:0] pt, input logic [127:0] key);
      int c;
      @(posedge clk); #1;
      in_data = pt; in_key = key; in_valid = 1'b1;
      wait_acc(c);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int start;
      bit ok;
      start = out_cnt; ok = 1'b0;
      for (int k = 0; k < 80 && !ok; k++) begin
         @(negedge clk); #1;
         if (out_cnt >= start + n) ok = 1'b1;
      end
      chk("output_timeout", 128'(ok), 128'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
      chk({tag, "_out_data"},  out_data,        128'd0);
      chk({tag, "_busy"},      128'(busy),      128'd0);
      chk({tag, "_round"},     128'(round),     128'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [127:0] held;
      int           c0, c1, a, o0, last_acc;
      bit           ok;

      build_sbox();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk_reset_vals("reset");
      chk("reset_state_reg", dut.state_q, 128'd0);
      chk("reset_key_reg",   dut.key_q,   128'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // App. B vector, round index trace and round-1 internal state
      send(B_PT, B_KEY);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); #1;
         chk("round_index", 128'(round), 128'(k));
         chk("busy_in_round", 128'(busy), 128'd1);
         chk("in_ready_in_round", 128'(in_ready), 128'd0);
         if (k == 1) chk("round0_state", dut.state_q, B_PT ^ B_KEY);
         if (k == 2) begin
            chk("round1_state", dut.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
            chk("round1_key",   dut.key_q,   128'ha0fafe1788542cb123a339392a6c7605);
         end
      end
      wait_out(1);
      chk("appB_ciphertext", last_out, B_CT);

      // App. C.1 vector
      send(C_PT, C_KEY);
      wait_out(1);
      chk("appC_ciphertext", last_out, C_CT);

      // Backpressure with an ignored second request
      @(posedge clk); #1;
      out_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk); #1;
         if (out_valid) ok = 1'b1;
      end
      chk("bp_valid_timeout", 128'(ok), 128'd1);
      held = out_data;
      a = acc_cnt;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk); #1;
         chk("bp_out_valid", 128'(out_valid), 128'd1);
         chk("bp_in_ready",  128'(in_ready),  128'd0);
         chk("bp_out_data",  out_data,        held);
      end
      chk("bp_no_accept", 128'(acc_cnt), 128'(a));
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      wait_out(1);
      @(negedge clk); #1;
      chk("bp_idle_in_ready",  128'(in_ready),  128'd1);
      chk("bp_idle_out_valid", 128'(out_valid), 128'd0);
      chk("bp_idle_round",     128'(round),     128'd0);
      chk("bp_idle_busy",      128'(busy),      128'd0);
      chk("bp_idle_hold_data", out_data,        held);

      // Back-to-back with in_data churn while busy
      o0 = out_cnt;
      @(posedge clk); #1;
      in_data = B_PT; in_key = B_KEY; in_valid = 1'b1;
      wait_acc(c0);
      @(posedge clk); #1;
      repeat (6) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         in_key  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
      end
      in_data = C_PT; in_key = C_KEY;
      wait_acc(c1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_accept_spacing", 128'(c1 - c0), 128'd12);
      wait_out(o0 + 2 - out_cnt);
      if (out_hist.size() >= o0 + 2) begin
         chk("b2b_first_ct",  out_hist[o0],     B_CT);
         chk("b2b_second_ct", out_hist[o0 + 1], C_CT);
      end else begin
         chk("b2b_output_count", 128'(out_hist.size()), 128'(o0 + 2));
      end

      // Randomized traffic with random backpressure
      last_acc = acc_cnt;
      for (int i = 0; i < 700; i++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc_cnt != last_acc) begin
            in_valid = 1'b0;
            last_acc = acc_cnt;
         end
         if (!in_valid && $urandom_range(0, 2) == 0) in_valid = 1'b1;
         if (in_valid) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
      end
      chk("random_drain", 128'(ok), 128'd1);
      chk("random_blocks_seen", 128'(acc_cnt > last_acc - 1), 128'd1);

      // Reset in the middle of round 5
      send(B_PT, B_KEY);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk); #1;
         if (round == 4'd5) ok = 1'b1;
      end
      chk("reach_round5", 128'(ok), 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         chk("midrst_no_out_valid", 128'(out_valid), 128'd0);
      end
      send(C_PT, C_KEY);
      wait_out(1);
      chk("midrst_fresh_ct", last_out, C_CT);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
